hdmi_link_supervisor: RTL and testbench
=======================================

// Module: hdmi_link_supervisor
// PURPOSE
//  Sequences the TMDS decoder's reset and qualifies its lock/valid status.
//  Sits between tmds_decoder and the user display module in the clk (12 MHz) domain:
//   - drives the decoder reset;
//   - waits for lock, then requires a stable-valid qualify window before declaring the link up;
//   - filters short dropouts with a leaky counter, retrains on long ones;
//   - reports state and retrain count for LEDs/UART.
// PARAMETERS
//  TIMER_W        21     width of the phase timer and the leak counter
//  RESET_CYCLES   1024   clk cycles hdmi_reset is held per reset phase (>=1)
//  LOCK_TIMEOUT   2**20  cycles allowed in WAIT_LOCK before a retrain (>=1)
//  QUALIFY_CYCLES 4096   consecutive good cycles required before link_up (>=1)
//  DROP_LIMIT     2**20  leak-counter value that forces a retrain from UP (>=1)
//  All limits must be < 2**TIMER_W.
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  hdmi_valid     in   1  decoder valid (hdmi_clk domain, async to clk)
//  hdmi_locked    in   1  decoder lock (hdmi_clk domain, async to clk)
//  force_retrain  in   1  one-cycle request to restart the link
//  hdmi_reset     out  1  reset to tmds_decoder
//  link_up        out  1  link qualified and running
//  link_state     out  2  0=RESET 1=WAIT_LOCK 2=QUALIFY 3=UP
//  retrain_count  out  8  saturating count of retrains
//  drop_pulse     out  1  one-cycle flag: UP lost by leak limit
// BEHAVIOUR
//  Reset and outputs
//  - Async reset: state=RESET, timer=0, leak=0, hdmi_reset=1, link_up=0,
//    retrain_count=0, drop_pulse=0, sync flops=0. All take effect immediately, no clock edge.
//  - Outputs are registered: they change on the same edge as the state register.
//  - hdmi_reset=1 exactly when state==RESET; link_up=1 exactly when state==UP.
//  Input synchronisation
//  - hdmi_valid and hdmi_locked each pass through a 2-flop synchroniser (valid_s, locked_s).
//  - good = valid_s & locked_s. All decisions use good: 2-cycle input latency.
//  RESET
//  - timer increments each cycle.
//  - At timer==RESET_CYCLES-1: go to WAIT_LOCK, timer=0.
//  WAIT_LOCK
//  - good: go to QUALIFY, timer=0.
//  - else at timer==LOCK_TIMEOUT-1: retrain.
//  QUALIFY
//  - !good in any cycle: retrain.
//  - At timer==QUALIFY_CYCLES-1 with good: go to UP, leak=0.
//  UP
//  - Each cycle: !good -> leak+1; good -> leak-1, floored at 0.
//  - If the next leak value == DROP_LIMIT: retrain, and drop_pulse=1 for the next cycle only.
//  Retrain
//  - Next state RESET, timer=0, leak=0.
//  - retrain_count+1, saturating at 255.
//  force_retrain (highest priority)
//  - In WAIT_LOCK/QUALIFY/UP: retrain. Counted once even if a timeout or drop coincides.
//    drop_pulse is then not asserted.
//  - In RESET: timer=0 (reset phase restarts), not counted.
//  Arithmetic
//  - timer and leak are TIMER_W bits and never wrap: both are bounded by their limits.
//  - retrain_count never wraps.
// TESTING  (RESET_CYCLES=4, LOCK_TIMEOUT=16, QUALIFY_CYCLES=8, DROP_LIMIT=5)
//  1 Release reset, valid=locked=1
//    -> hdmi_reset high 4 cycles; WAIT_LOCK for 2 cycles (sync delay); QUALIFY 8 cycles;
//       link_up=1 on the next edge; retrain_count=0.
//  2 locked held 0
//    -> RESET(4)/WAIT_LOCK(16) loop; retrain_count increments once per loop.
//    -> After 300 loops retrain_count==255 and stays 255.
//  3 In UP, valid low 4 cycles then high
//    -> stays UP; leak peaks at 4 and returns to 0.
//  4 In UP, valid low 5 cycles
//    -> RESET, drop_pulse high exactly 1 cycle, retrain_count+1.
//  5 Glitch !good for 1 cycle mid-QUALIFY
//    -> RESET, retrain_count+1, link_up never asserted.
//  6 force_retrain coinciding with leak reaching 5
//    -> single increment, drop_pulse=0.
//  7 force_retrain in RESET at timer=2
//    -> RESET lasts 4 more cycles, no increment.
//  8 Async reset asserted mid-UP between edges
//    -> link_up=0, hdmi_reset=1, retrain_count=0 immediately.

Source files
------------

// File: rtl/hdmi_link_supervisor.sv
// Supervises the TMDS decoder: sequences its reset, then qualifies lock/valid before link up.
// Short dropouts are absorbed by a leaky counter; long ones or timeouts force a retrain.
module hdmi_link_supervisor #(
    parameter int unsigned TIMER_W        = 21,
    parameter int unsigned RESET_CYCLES   = 1024,
    parameter int unsigned LOCK_TIMEOUT   = 2**20,
    parameter int unsigned QUALIFY_CYCLES = 4096,
    parameter int unsigned DROP_LIMIT     = 2**20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hdmi_valid,
    input  logic       i_hdmi_locked,
    input  logic       i_force_retrain,
    output logic       o_hdmi_reset,
    output logic       o_link_up,
    output logic [1:0] o_link_state,
    output logic [7:0] o_retrain_count,
    output logic       o_drop_pulse
);

    typedef enum logic [1:0] {
        StReset    = 2'd0,
        StWaitLock = 2'd1,
        StQualify  = 2'd2,
        StUp       = 2'd3
    } state_e;

    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] QUALIFY_LAST = TIMER_W'(QUALIFY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LEAK_LIMIT   = TIMER_W'(DROP_LIMIT);

    state_e               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   r_leak;
    logic [7:0]           r_retrain_count;
    logic                 r_drop_pulse;
    logic                 r_hdmi_reset;
    logic                 r_link_up;
    logic                 r_valid_meta, r_valid_s;
    logic                 r_locked_meta, r_locked_s;

    state_e               w_state_d;
    logic [TIMER_W-1:0]   w_timer_d;
    logic [TIMER_W-1:0]   w_leak_d;
    logic [TIMER_W-1:0]   w_leak_step;
    logic                 w_retrain;
    logic                 w_drop_d;
    logic                 w_good;

    // Decoder status lives in the hdmi_clk domain; two-flop synchronise each bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid_meta  <= 1'b0;
            r_valid_s     <= 1'b0;
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
        end else begin
            r_valid_meta  <= i_hdmi_valid;
            r_valid_s     <= r_valid_meta;
            r_locked_meta <= i_hdmi_locked;
            r_locked_s    <= r_locked_meta;
        end
    end

    assign w_good = r_valid_s & r_locked_s;

    always_comb begin
        if (!w_good) begin
            w_leak_step = r_leak + 1'b1;
        end else if (r_leak == '0) begin
            w_leak_step = '0;
        end else begin
            w_leak_step = r_leak - 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_leak_d  = r_leak;
        w_retrain = 1'b0;
        w_drop_d  = 1'b0;
        unique case (r_state)
            StReset: begin
                if (i_force_retrain) begin
                    w_timer_d = '0;
                end else if (r_timer == RESET_LAST) begin
                    w_state_d = StWaitLock;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StWaitLock: begin
                if (i_force_retrain) begin
                    w_retrain = 1'b1;
                end else if (w_good) begin
                    w_state_d = StQualify;
                    w_timer_d = '0;
                end else if (r_timer == LOCK_LAST) begin
                    w_retrain = 1'b1;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StQualify: begin
                if (i_force_retrain || !w_good) begin
                    w_retrain = 1'b1;
                end else if (r_timer == QUALIFY_LAST) begin
                    w_state_d = StUp;
                    w_timer_d = '0;
                    w_leak_d  = '0;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StUp: begin
                if (i_force_retrain) begin
                    w_retrain = 1'b1;
                end else if (w_leak_step == LEAK_LIMIT) begin
                    w_retrain = 1'b1;
                    w_drop_d  = 1'b1;
                end else begin
                    w_leak_d = w_leak_step;
                end
            end
            default: w_state_d = StReset;
        endcase
        if (w_retrain) begin
            w_state_d = StReset;
            w_timer_d = '0;
            w_leak_d  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= StReset;
            r_timer         <= '0;
            r_leak          <= '0;
            r_retrain_count <= 8'd0;
            r_drop_pulse    <= 1'b0;
            r_hdmi_reset    <= 1'b1;
            r_link_up       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_timer      <= w_timer_d;
            r_leak       <= w_leak_d;
            r_drop_pulse <= w_drop_d;
            r_hdmi_reset <= (w_state_d == StReset);
            r_link_up    <= (w_state_d == StUp);
            if (w_retrain && (r_retrain_count != 8'hFF)) begin
                r_retrain_count <= r_retrain_count + 8'd1;
            end
        end
    end

    assign o_hdmi_reset    = r_hdmi_reset;
    assign o_link_up       = r_link_up;
    assign o_link_state    = r_state;
    assign o_retrain_count = r_retrain_count;
    assign o_drop_pulse    = r_drop_pulse;

endmodule

// File: tb/tb_hdmi_link_supervisor.sv
// Directed bench for hdmi_link_supervisor with small limits (4/16/8/5); expectations are
// hand-derived cycle by cycle, counting edges from each reset release.
module tb_hdmi_link_supervisor;

    logic       clk = 1'b0;
    logic       reset;
    logic       hdmi_valid;
    logic       hdmi_locked;
    logic       force_retrain;
    logic       hdmi_reset;
    logic       link_up;
    logic [1:0] link_state;
    logic [7:0] retrain_count;
    logic       drop_pulse;

    int checks = 0;
    int errors = 0;

    hdmi_link_supervisor #(
        .TIMER_W        (21),
        .RESET_CYCLES   (4),
        .LOCK_TIMEOUT   (16),
        .QUALIFY_CYCLES (8),
        .DROP_LIMIT     (5)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_hdmi_valid    (hdmi_valid),
        .i_hdmi_locked   (hdmi_locked),
        .i_force_retrain (force_retrain),
        .o_hdmi_reset    (hdmi_reset),
        .o_link_up       (link_up),
        .o_link_state    (link_state),
        .o_retrain_count (retrain_count),
        .o_drop_pulse    (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // State plus the two outputs that decode it.
    task automatic chk_st(input string tag, input int st);
        chk({tag, ".state"}, 32'(link_state), 32'(st));
        chk({tag, ".hdmi_reset"}, 32'(hdmi_reset), (st == 0) ? 32'd1 : 32'd0);
        chk({tag, ".link_up"}, 32'(link_up), (st == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int leak_a[8] = '{1, 2, 3, 4, 3, 2, 1, 0};

    initial begin
        reset = 1'b1;
        hdmi_valid = 1'b0;
        hdmi_locked = 1'b0;
        force_retrain = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_st("rst", 0);
        chk("rst.count", 32'(retrain_count), 0);
        chk("rst.drop", 32'(drop_pulse), 0);
        reset = 1'b0;

        // Bring-up; inputs rise in the last reset cycle so WAIT_LOCK sees 2 sync cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("up.reset", 0);
        end
        hdmi_valid = 1'b1;
        hdmi_locked = 1'b1;
        step(); chk_st("up.wait0", 1);
        step(); chk_st("up.wait1", 1);
        step(); chk_st("up.qual0", 2);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_st("up.qual", 2);
        end
        step(); chk_st("up.up", 3);
        chk("up.count", 32'(retrain_count), 0);

        // Four-cycle dropout is absorbed.
        hdmi_valid = 1'b0;
        step(); chk_st("leak4.sync0", 3);
        step(); chk_st("leak4.sync1", 3);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_st("leak4.state", 3);
            chk("leak4.leak", 32'(dut.r_leak), 32'(leak_a[i]));
            if (i == 1) hdmi_valid = 1'b1;
        end

        // Five-cycle dropout hits the limit.
        hdmi_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk_st("drop.state", 3);
            chk("drop.leak", 32'(dut.r_leak), 32'(i + 1));
            if (i == 2) hdmi_valid = 1'b1;
        end
        step(); chk_st("drop.retrain", 0);
        chk("drop.pulse", 32'(drop_pulse), 1);
        chk("drop.count", 32'(retrain_count), 1);
        step(); chk("drop.pulse_clr", 32'(drop_pulse), 0);
        step(); step(); chk_st("drop.reset3", 0);
        step(); chk_st("drop.wait", 1);
        step(); chk_st("drop.qual", 2);

        // One-cycle lock glitch in QUALIFY.
        step(); step();
        hdmi_locked = 1'b0;
        step(); chk_st("glitch.q", 2);
        hdmi_locked = 1'b1;
        step(); chk_st("glitch.q2", 2);
        step(); chk_st("glitch.retrain", 0);
        chk("glitch.count", 32'(retrain_count), 2);

        // force_retrain in RESET at timer=2 restarts the reset phase.
        step(); step();
        chk("frst.timer", dut.r_timer, 2);
        force_retrain = 1'b1;
        step(); chk_st("frst.hold", 0);
        force_retrain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("frst.reset", 0);
        end
        chk("frst.count", 32'(retrain_count), 2);
        step(); chk_st("frst.wait", 1);
        step(); chk_st("frst.qual", 2);
        repeat (7) step();
        step(); chk_st("frst.up", 3);

        // force_retrain on the same edge the leak would reach the limit.
        hdmi_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("coin.leak", 32'(dut.r_leak), 32'(i + 1));
        end
        force_retrain = 1'b1;
        step(); chk_st("coin.retrain", 0);
        chk("coin.drop", 32'(drop_pulse), 0);
        chk("coin.count", 32'(retrain_count), 3);
        force_retrain = 1'b0;
        hdmi_valid = 1'b1;
        step(); chk("coin.drop2", 32'(drop_pulse), 0);
        chk("coin.count2", 32'(retrain_count), 3);
        step(); step();
        step(); chk_st("coin.wait", 1);
        step(); chk_st("coin.qual", 2);
        repeat (7) step();
        step(); chk_st("coin.up", 3);

        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1;
        chk_st("async", 0);
        chk("async.count", 32'(retrain_count), 0);
        chk("async.drop", 32'(drop_pulse), 0);

        // No lock: RESET(4)/WAIT_LOCK(16) loop, count saturates at 255.
        hdmi_locked = 1'b0;
        step(); step();
        reset = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            repeat (19) step();
            chk_st("loop.wait", 1);
            chk("loop.count_pre", 32'(retrain_count), (n - 1 > 255) ? 32'd255 : 32'(n - 1));
            step();
            chk_st("loop.reset", 0);
            chk("loop.count", 32'(retrain_count), (n > 255) ? 32'd255 : 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
